// File: rtl/simon_note_player.sv
// Simon note playback sequencer.
// Pops notes off the stack and plays each as a gated tone followed by a gap.
module simon_note_player #(
    parameter int DATA_WIDTH  = 2,
    parameter int DEPTH       = 16,
    parameter int TONE_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 5_000_000
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic                         i_stack_empty,
    input  logic [DATA_WIDTH-1:0]        i_stack_data,
    output logic                         o_stack_pop,
    output logic [DATA_WIDTH-1:0]        o_note_sel,
    output logic                         o_note_en,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [$clog2(DEPTH+1)-1:0]   o_note_count
);

    localparam int MAXC = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int CW   = $clog2(DEPTH + 1);

    localparam logic [TW-1:0] TONE_LD = TW'(TONE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_TONE,
        S_GAP,
        S_FINISH
    } state_t;

    state_t                r_state;
    logic [TW-1:0]         r_timer;
    logic [DATA_WIDTH-1:0] r_note_sel;
    logic                  r_note_en;
    logic                  r_busy;
    logic                  r_done;
    logic [CW-1:0]         r_count;
    logic                  w_pop;

    // Pop strobe is suppressed by reset and abort so no note is lost mid-cancel.
    assign w_pop = (r_state == S_FETCH) & ~i_stack_empty & ~i_abort & ~i_rst;

    assign o_stack_pop  = w_pop;
    assign o_note_sel   = r_note_sel;
    assign o_note_en    = r_note_en;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_note_count = r_count;

    // Playback FSM with registered outputs; reset beats abort beats start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_note_sel <= '0;
            r_note_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_count    <= '0;
        end else if (i_abort && (r_state != S_IDLE)) begin
            r_state   <= S_IDLE;
            r_note_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_start && !i_abort) begin
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        if (i_stack_empty) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (!i_stack_empty) begin
                        r_note_sel <= i_stack_data;
                        if (r_count != CNT_MAX) begin
                            r_count <= r_count + 1'b1;
                        end
                        r_timer   <= TONE_LD;
                        r_note_en <= 1'b1;
                        r_state   <= S_TONE;
                    end else begin
                        r_state <= S_FINISH;
                        r_done  <= 1'b1;
                    end
                end
                S_TONE: begin
                    if (r_timer == '0) begin
                        r_timer   <= GAP_LD;
                        r_note_en <= 1'b0;
                        r_state   <= S_GAP;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_timer == '0) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_note_player.sv
// Scoreboard bench for simon_note_player.
// Stimulus queues expected events/samples; a monitor pops and compares them.
module tb_simon_note_player;

    localparam int DW = 2;
    localparam int DP = 4;
    localparam int CW = $clog2(DP + 1);

    localparam int EV_POP  = 0;
    localparam int EV_ON   = 1;
    localparam int EV_OFF  = 2;
    localparam int EV_DONE = 3;

    localparam int F_ALL  = 0;
    localparam int F_BUSY = 1;
    localparam int F_CNT  = 2;
    localparam int F_SEL  = 3;
    localparam int F_PEND = 4;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    typedef struct {
        int cyc;
        int field;
        int val;
    } sq_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          stack_empty;
    logic [DW-1:0] stack_data;
    logic          pop;
    logic [DW-1:0] note_sel;
    logic          note_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] note_count;

    logic [DW-1:0] stk [0:7];
    int load_sp  = 0;
    int pop_base = 0;
    int pop_cnt  = 0;
    int sp_eff;
    int cyc      = 0;
    int base     = 0;
    int checks   = 0;
    int passes   = 0;
    logic prev_en = 1'b0;

    ev_t exq[$];
    sq_t sq[$];

    assign sp_eff      = load_sp - (pop_cnt - pop_base);
    assign stack_empty = (sp_eff <= 0);
    assign stack_data  = (sp_eff > 0) ? stk[sp_eff-1] : '0;

    simon_note_player #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP),
        .TONE_CYCLES(4),
        .GAP_CYCLES (2)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_abort      (abort),
        .i_stack_empty(stack_empty),
        .i_stack_data (stack_data),
        .o_stack_pop  (pop),
        .o_note_sel   (note_sel),
        .o_note_en    (note_en),
        .o_busy       (busy),
        .o_done       (done),
        .o_note_count (note_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pop && sp_eff > 0) pop_cnt <= pop_cnt + 1;
    end

    function automatic string kname(input int k);
        case (k)
            EV_POP:  return "POP";
            EV_ON:   return "EN_RISE";
            EV_OFF:  return "EN_FALL";
            default: return "DONE";
        endcase
    endfunction

    function automatic string fname(input int f);
        case (f)
            F_ALL:   return "all_outputs";
            F_BUSY:  return "busy";
            F_CNT:   return "note_count";
            F_SEL:   return "note_sel";
            default: return "pending_events";
        endcase
    endfunction

    task automatic observe(input int kind, input int val);
        ev_t e;
        checks++;
        if (exq.size() == 0) begin
            $display("FAIL unexpected_event: got %s@%0d val %0d, required none",
                     kname(kind), cyc, val);
        end else begin
            e = exq.pop_front();
            if (e.kind == kind && e.cyc == cyc && e.val == val)
                passes++;
            else
                $display("FAIL event: got %s@%0d val %0d, required %s@%0d val %0d",
                         kname(kind), cyc, val, kname(e.kind), e.cyc, e.val);
        end
    endtask

    function automatic int sample(input int f);
        case (f)
            F_ALL:   return int'({pop, note_sel, note_en, busy, done, note_count});
            F_BUSY:  return int'(busy);
            F_CNT:   return int'(note_count);
            F_SEL:   return int'(note_sel);
            default: return exq.size();
        endcase
    endfunction

    always @(negedge clk) begin
        sq_t s;
        int  a;
        if (pop)                 observe(EV_POP, 0);
        if (note_en && !prev_en) observe(EV_ON, int'(note_sel));
        if (!note_en && prev_en) observe(EV_OFF, 0);
        if (done)                observe(EV_DONE, int'(note_count));
        prev_en = note_en;
        while (sq.size() > 0 && sq[0].cyc <= cyc) begin
            s = sq.pop_front();
            a = sample(s.field);
            checks++;
            if (a == s.val && s.cyc == cyc)
                passes++;
            else
                $display("FAIL %s@%0d: got %0d, required %0d (sampled at %0d)",
                         fname(s.field), s.cyc, a, s.val, cyc);
        end
    end

    task automatic ev(input int kind, input int rel, input int val);
        exq.push_back('{kind, base + rel, val});
    endtask

    task automatic sc(input int rel, input int field, input int val);
        sq.push_back('{base + rel, field, val});
    endtask

    task automatic wait_to(input int rel);
        while (cyc < base + rel) @(negedge clk);
    endtask

    task automatic load_213();
        stk[0]   = 2'd3;
        stk[1]   = 2'd1;
        stk[2]   = 2'd2;
        pop_base = pop_cnt;
        load_sp  = 3;
    endtask

    task automatic exp_full_run();
        ev(EV_POP, 1, 0);  ev(EV_ON, 2, 2);  ev(EV_OFF, 6, 0);
        ev(EV_POP, 8, 0);  ev(EV_ON, 9, 1);  ev(EV_OFF, 13, 0);
        ev(EV_POP, 15, 0); ev(EV_ON, 16, 3); ev(EV_OFF, 20, 0);
        ev(EV_DONE, 23, 3);
        sc(1, F_BUSY, 1);
        sc(22, F_BUSY, 1);
        sc(23, F_CNT, 3);
        sc(24, F_BUSY, 0);
        sc(24, F_SEL, 3);
        sc(26, F_PEND, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 8; i++) stk[i] = DW'($urandom_range(0, 3));
        load_sp = $urandom_range(0, 3);

        // Test 1: reset with random inputs
        base = 0;
        sc(1, F_ALL, 0);
        sc(2, F_ALL, 0);
        sc(3, F_ALL, 0);
        sc(4, F_ALL, 0);
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom_range(0, 1));
            abort = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        wait_to(6);

        // Test 2: play 2,1,3
        load_213();
        base = cyc;
        exp_full_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_to(28);

        // Test 3: empty stack
        load_sp = 0;
        pop_base = pop_cnt;
        base = cyc;
        ev(EV_DONE, 1, 0);
        sc(1, F_BUSY, 1);
        sc(1, F_CNT, 0);
        sc(2, F_BUSY, 0);
        sc(10, F_PEND, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_to(12);

        // Test 4: abort in second tone cycle
        load_213();
        base = cyc;
        ev(EV_POP, 1, 0);
        ev(EV_ON, 2, 2);
        ev(EV_OFF, 4, 0);
        sc(3, F_BUSY, 1);
        sc(4, F_BUSY, 0);
        sc(4, F_CNT, 1);
        sc(20, F_PEND, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_to(3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_to(22);

        // Test 5a: start pulses during gaps are ignored
        load_213();
        base = cyc;
        exp_full_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_to(6);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_to(13);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_to(28);

        // Test 5b: reset during gap
        load_213();
        base = cyc;
        ev(EV_POP, 1, 0);
        ev(EV_ON, 2, 2);
        ev(EV_OFF, 6, 0);
        sc(5, F_CNT, 1);
        sc(7, F_ALL, 0);
        sc(20, F_PEND, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_to(6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_to(22);

        // Test 6: abort and start together in idle
        load_213();
        base = cyc;
        sc(1, F_ALL, 0);
        sc(2, F_ALL, 0);
        sc(10, F_PEND, 0);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        wait_to(12);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
